// File: rtl/truth_table_sweeper.sv
// Steps a 3-input gate through rows 000..111, samples its output and assembles the measured truth table.
// Latency: 8*(1+SETTLE+SAMPLES) cycles from accepted start to done; start is ignored while busy.
module truth_table_sweeper #(
    parameter logic [7:0]  EXPECTED = 8'h6E,
    parameter int unsigned SETTLE   = 4,
    parameter int unsigned SAMPLES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic [7:0] unstable,
    output logic       pass
);
    localparam logic [7:0] SETTLE_LD  = 8'(SETTLE);
    localparam logic [3:0] SAMPLES_LD = 4'(SAMPLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] row_q, row_d;
    logic [2:0] in_q, in_d;
    logic [7:0] settle_cnt_q, settle_cnt_d;
    logic [3:0] sample_cnt_q, sample_cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] table_q, table_d;
    logic [7:0] unstable_q, unstable_d;
    logic [2:0] bit_idx;

    assign bit_idx = 3'd7 - row_q;

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        in_d         = in_q;
        settle_cnt_d = settle_cnt_q;
        sample_cnt_d = sample_cnt_q;
        busy_d       = busy_q;
        done_d       = done_q;
        table_d      = table_q;
        unstable_d   = unstable_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_DRIVE;
                    row_d      = 3'd0;
                    in_d       = 3'd0;
                    table_d    = 8'h00;
                    unstable_d = 8'h00;
                    done_d     = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_DRIVE: begin
                in_d         = row_q;
                settle_cnt_d = SETTLE_LD;
                state_d      = ST_SETTLE;
            end
            ST_SETTLE: begin
                // The edge that ends the settle window captures the first sample.
                if (settle_cnt_q == 8'd1) begin
                    table_d[bit_idx] = dut_out;
                    sample_cnt_d     = SAMPLES_LD;
                    state_d          = ST_SAMPLE;
                end else begin
                    settle_cnt_d = settle_cnt_q - 8'd1;
                end
            end
            ST_SAMPLE: begin
                if (sample_cnt_q == 4'd1) begin
                    if (row_q == 3'd7) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        row_d   = row_q + 3'd1;
                        in_d    = row_q + 3'd1;
                        state_d = ST_DRIVE;
                    end
                end else begin
                    if (dut_out != table_q[bit_idx]) begin
                        unstable_d[bit_idx] = 1'b1;
                    end
                    sample_cnt_d = sample_cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            row_q        <= 3'd0;
            in_q         <= 3'd0;
            settle_cnt_q <= 8'd0;
            sample_cnt_q <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            table_q      <= 8'h00;
            unstable_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            in_q         <= in_d;
            settle_cnt_q <= settle_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            table_q      <= table_d;
            unstable_q   <= unstable_d;
        end
    end

    assign in1       = in_q[2];
    assign in2       = in_q[1];
    assign in3       = in_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign table_out = table_q;
    assign unstable  = unstable_q;
    assign pass      = done_q && (table_q == EXPECTED) && (unstable_q == 8'h00);
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a delayed, glitchable gate model feeds the sweeper; a scoreboard
// of tables predicted from the sweep timing is compared whenever done rises.
module tb_truth_table_sweeper;
    localparam int SETTLE  = 4;
    localparam int SAMPLES = 2;
    localparam int R       = 1 + SETTLE + SAMPLES;
    localparam logic [7:0] EXP_TBL = 8'h6E;

    typedef struct {
        logic [7:0] tbl;
        logic [7:0] unst;
        logic       pass;
        int         e0;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, start, dut_out;
    logic       in1, in2, in3, busy, done, pass;
    logic [7:0] table_out, unstable;

    truth_table_sweeper #(.EXPECTED(EXP_TBL), .SETTLE(SETTLE), .SAMPLES(SAMPLES)) dut (
        .clk(clk), .reset(reset), .start(start), .dut_out(dut_out),
        .in1(in1), .in2(in2), .in3(in3), .busy(busy), .done(done),
        .table_out(table_out), .unstable(unstable), .pass(pass)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Gate under test: table lookup, optionally delayed by whole cycles, optionally inverted for one cycle.
    logic [7:0] gate_tbl   = 8'h6E;
    int         gate_delay = 0;
    int         glitch_n   = -1;
    int         e0         = 0;
    bit         act        = 1'b0;
    logic [7:0] pipe       = 8'h00;
    logic       gate_now, glitch;

    always @(posedge clk) pipe <= {pipe[6:0], gate_tbl[3'd7 - {in1, in2, in3}]};

    always_comb begin
        gate_now = gate_tbl[3'd7 - {in1, in2, in3}];
        glitch   = act && (glitch_n >= 0) && ((cyc - e0) == glitch_n);
        dut_out  = ((gate_delay == 0) ? gate_now : pipe[gate_delay - 1]) ^ glitch;
    end

    // Interval n after the start edge shows row n/R; sample j of row k reads interval R*k+SETTLE+j.
    function automatic exp_t model(input logic [7:0] tbl, input int d, input int g,
                                   input logic [2:0] prev, input int e0v);
        exp_t r;
        int n, m;
        logic v;
        logic [2:0] row_in;
        r.tbl  = 8'h00;
        r.unst = 8'h00;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < SAMPLES; j++) begin
                n = R * k + SETTLE + j;
                m = n - d;
                row_in = (m < 0) ? prev : 3'(m / R);
                v = tbl[7 - row_in] ^ (n == g);
                if (j == 0) r.tbl[7 - k] = v;
                else if (v != r.tbl[7 - k]) r.unst[7 - k] = 1'b1;
            end
        end
        r.pass = (r.tbl == EXP_TBL) && (r.unst == 8'h00);
        r.e0   = e0v;
        return r;
    endfunction

    exp_t sb[$];
    logic done_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        int n;
        if (act) begin
            n = cyc - e0;
            if (n >= 0 && n < 8 * R && n % R == 0) check("in_step", {in1, in2, in3}, n / R);
        end
        if (done && !done_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("table_out", table_out, e.tbl);
                check("unstable", unstable, e.unst);
                check("pass", pass, e.pass);
                check("done_latency", cyc - e.e0, 8 * R);
            end
        end
        done_prev <= done;
    end

    logic [2:0] prev_in = 3'b000;

    task automatic set_gate(input logic [7:0] tbl, input int d);
        gate_tbl   = tbl;
        gate_delay = d;
        repeat (10) @(negedge clk);
    endtask

    task automatic launch(input int g, input bit hold);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        e0       = cyc;
        glitch_n = g;
        act      = 1'b1;
        e = model(gate_tbl, gate_delay, g, prev_in, cyc);
        sb.push_back(e);
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 8 * R + 20; k++) begin
            @(negedge clk);
            if (done) break;
        end
        check({name, "_done_seen"}, done, 1);
        act     = 1'b0;
        prev_in = 3'b111;
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_in"}, {in1, in2, in3}, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_pass"}, pass, 0);
        check({name, "_table"}, table_out, 0);
        check({name, "_unstable"}, unstable, 0);
    endtask

    initial begin
        exp_t e;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;

        set_gate(8'h6E, 0); launch(-1, 1'b0); wait_done("ideal");
        set_gate(8'h76, 0); launch(-1, 1'b0); wait_done("wrong_fn");
        set_gate(8'h6E, 0); launch(3 * R + SETTLE + 1, 1'b0); wait_done("glitch");
        set_gate(8'h6E, SETTLE); launch(-1, 1'b0); wait_done("delay_eq_settle");
        set_gate(8'h6E, SETTLE + 1); launch(-1, 1'b0); wait_done("delay_over_settle");

        // start pulsed during row 2 must not restart the sweep
        set_gate(8'h6E, 0);
        launch(-1, 1'b0);
        for (int k = 0; k < 8 * R && (cyc - e0) < 2 * R + 1; k++) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        wait_done("busy_start");

        // reset during row 5 abandons the sweep
        launch(-1, 1'b0);
        for (int k = 0; k < 8 * R && (cyc - e0) < 5 * R + 1; k++) @(negedge clk);
        act   = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        void'(sb.pop_back());
        prev_in = 3'b000;
        check_reset_vals("mid_reset");
        launch(-1, 1'b0);
        wait_done("after_reset");

        // start held high restarts on the edge after done rises
        launch(-1, 1'b1);
        wait_done("hold_first");
        e = model(gate_tbl, gate_delay, -1, prev_in, e0 + 8 * R + 1);
        sb.push_back(e);
        e0  = e0 + 8 * R + 1;
        act = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_busy", busy, 1);
        check("restart_done", done, 0);
        wait_done("hold_second");

        for (int i = 0; i < 8; i++) begin
            set_gate(8'($urandom), int'($urandom_range(0, SETTLE + 2)));
            launch(($urandom_range(0, 1) == 1) ? int'($urandom_range(SETTLE, 8 * R - 1)) : -1, 1'b0);
            wait_done("random");
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run so far", tests);
        $fatal(1, "watchdog");
    end
endmodule
